// File: rtl/riscv_cache_arb_pkg.sv
// -----------------------------------------------------------------------------
// riscv_cache_arb_pkg
//
// Shared types and constants for the cache front-end arbiter.
//   cache_arb_state_e : controller phase (array clear walk, then arbitration)
//   CACHE_DEPTH       : default number of cache entries
//   rr_wrap()         : rotating-priority index helper for the round-robin scan
// -----------------------------------------------------------------------------
package riscv_cache_arb_pkg;

    localparam int CACHE_DEPTH = 256;

    typedef enum logic [0:0] {
        ARB_INIT,
        ARB_RUN
    } cache_arb_state_e;

    // Index reached after stepping 'offset' places past 'base' in a ring of n.
    function automatic int rr_wrap(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/riscv_cache_arb_if.sv
// -----------------------------------------------------------------------------
// riscv_cache_arb_if
//
// Requester-side bus of the cache arbiter. Signal prefixes are relative to the
// arbiter (i_ = into the arbiter, o_ = out of it).
//   i_req_valid/o_req_ready : per-requester request handshake (ready is one-hot)
//   i_req_write             : 1 = write, 0 = read
//   i_req_addr/i_req_wdata  : per-requester address and write data
//   o_rsp_valid/i_rsp_ready : per-requester read response handshake
//   o_rsp_data              : shared read data, valid for the flagged requester
// Modports: slave = the arbiter, master = the requesters.
// -----------------------------------------------------------------------------
interface riscv_cache_arb_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);

    logic [NUM_REQ-1:0]                 i_req_valid;
    logic [NUM_REQ-1:0]                 o_req_ready;
    logic [NUM_REQ-1:0]                 i_req_write;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] i_req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_req_wdata;
    logic [NUM_REQ-1:0]                 o_rsp_valid;
    logic [NUM_REQ-1:0]                 i_rsp_ready;
    logic [DATA_WIDTH-1:0]              o_rsp_data;

    modport slave (
        input  i_req_valid,
        input  i_req_write,
        input  i_req_addr,
        input  i_req_wdata,
        input  i_rsp_ready,
        output o_req_ready,
        output o_rsp_valid,
        output o_rsp_data
    );

    modport master (
        output i_req_valid,
        output i_req_write,
        output i_req_addr,
        output i_req_wdata,
        output i_rsp_ready,
        input  o_req_ready,
        input  o_rsp_valid,
        input  o_rsp_data
    );

endinterface

// File: rtl/riscv_cache_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_rr_arbiter
//
// Purely combinational round-robin picker.
//   i_eligible    : requesters that may be granted this cycle
//   i_last_grant  : index granted most recently; scanning starts one above it
//   o_grant       : one-hot grant (zero when nothing is eligible)
//   o_grant_idx   : binary index of the grant
//   o_grant_valid : any grant this cycle
// -----------------------------------------------------------------------------
module riscv_rr_arbiter
    import riscv_cache_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_valid
);

    logic [IDX_W-1:0] scan_idx;

    // NOTE: every variable written in an always_comb gets a default at the top
    // of the block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        scan_idx      = '0;
        // Offsets 1..NUM_REQ visit every requester once, ending on the last
        // winner itself, so it only wins again if nobody else is eligible.
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IDX_W'(rr_wrap(int'(i_last_grant), k, NUM_REQ));
            if (!o_grant_valid && i_eligible[scan_idx]) begin
                o_grant_valid     = 1'b1;
                o_grant_idx       = scan_idx;
                o_grant[scan_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_cache_arb.sv
// -----------------------------------------------------------------------------
// riscv_cache_arb
//
// Front-end controller for the synchronous-read cache array. After reset it
// walks every index writing zero, then arbitrates the array round-robin
// between NUM_REQ requesters, issuing at most one read or write per cycle.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_enable        : 0 freezes grants and the clear walk
//   bus (slave)     : requester handshake / response bus
//   o_cache_enable  : cache enable, constant 1
//   o_cache_read    : read strobe, o_cache_rd_addr is the index
//   o_cache_write   : write strobe, o_cache_wr_addr / o_cache_data
//   i_cache_data    : cache registered read data (holds while no read issued)
//   o_init_done     : array cleared, arbitration running
//
// Read responses come straight from the cache's output register. That register
// only changes on a read, so a response that is being back-pressured is kept
// stable simply by not issuing another read until it is accepted.
// -----------------------------------------------------------------------------
module riscv_cache_arb
    import riscv_cache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = CACHE_DEPTH,
    parameter int NUM_REQ    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_enable,
    riscv_cache_arb_if.slave      bus,
    output logic                  o_cache_enable,
    output logic                  o_cache_read,
    output logic                  o_cache_write,
    output logic [ADDR_WIDTH-1:0] o_cache_rd_addr,
    output logic [ADDR_WIDTH-1:0] o_cache_wr_addr,
    output logic [DATA_WIDTH-1:0] o_cache_data,
    input  logic [DATA_WIDTH-1:0] i_cache_data,
    output logic                  o_init_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int REQ_W = $clog2(NUM_REQ);

    // Registered state
    cache_arb_state_e state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic             rsp_pend_q, rsp_pend_d;
    logic [REQ_W-1:0] rsp_id_q, rsp_id_d;
    logic [REQ_W-1:0] last_grant_q, last_grant_d;

    // Combinational arbitration signals
    logic                  active;
    logic                  rsp_accept;
    logic                  read_ok;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [REQ_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  grant_write;
    logic [IDX_W-1:0]      grant_index;
    logic [DATA_WIDTH-1:0] grant_wdata;
    logic                  unused_addr_bits;

    // A cycle with reset asserted issues nothing: any handshake completed then
    // would be lost when the pending response is dropped.
    assign active     = i_enable && !reset;
    assign rsp_accept = rsp_pend_q && bus.i_rsp_ready[rsp_id_q];
    // A new read may be issued only once the cache output register is free,
    // i.e. nothing is pending or the pending data leaves this cycle.
    assign read_ok    = !rsp_pend_q || rsp_accept;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = (state_q == ARB_RUN) && active && bus.i_req_valid[i] &&
                          (bus.i_req_write[i] || read_ok);
        end
    end

    riscv_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_eligible    (eligible),
        .i_last_grant  (last_grant_q),
        .o_grant       (grant),
        .o_grant_idx   (grant_idx),
        .o_grant_valid (grant_valid)
    );

    assign grant_write = bus.i_req_write[grant_idx];
    assign grant_index = bus.i_req_addr[grant_idx][IDX_W-1:0];
    assign grant_wdata = bus.i_req_wdata[grant_idx];

    // Address bits above the index are ignored, so accesses wrap modulo DEPTH.
    assign unused_addr_bits = ^bus.i_req_addr;

    assign bus.o_req_ready = grant;
    assign bus.o_rsp_data  = i_cache_data;
    assign o_cache_enable  = 1'b1;
    assign o_init_done     = (state_q == ARB_RUN);

    always_comb begin
        bus.o_rsp_valid = '0;
        if (rsp_pend_q) begin
            bus.o_rsp_valid[rsp_id_q] = 1'b1;
        end
    end

    // Next state and cache strobes. A read grant in the accept cycle overrides
    // the clear, so back-to-back reads keep rsp_pend set with the new id.
    always_comb begin
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        rsp_pend_d      = rsp_pend_q;
        rsp_id_d        = rsp_id_q;
        last_grant_d    = last_grant_q;
        o_cache_read    = 1'b0;
        o_cache_write   = 1'b0;
        o_cache_rd_addr = '0;
        o_cache_wr_addr = '0;
        o_cache_data    = '0;

        if (rsp_accept) begin
            rsp_pend_d = 1'b0;
        end

        case (state_q)
            ARB_INIT: begin
                if (active) begin
                    o_cache_write   = 1'b1;
                    o_cache_wr_addr = ADDR_WIDTH'(init_cnt_q);
                    init_cnt_d      = init_cnt_q + IDX_W'(1);
                    if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_d = ARB_RUN;
                    end
                end
            end
            ARB_RUN: begin
                if (grant_valid) begin
                    last_grant_d = grant_idx;
                    if (grant_write) begin
                        o_cache_write   = 1'b1;
                        o_cache_wr_addr = ADDR_WIDTH'(grant_index);
                        o_cache_data    = grant_wdata;
                    end else begin
                        o_cache_read    = 1'b1;
                        o_cache_rd_addr = ADDR_WIDTH'(grant_index);
                        rsp_pend_d      = 1'b1;
                        rsp_id_d        = grant_idx;
                    end
                end
            end
            default: begin
                state_d = ARB_INIT;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the clock edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_INIT;
            init_cnt_q   <= '0;
            rsp_pend_q   <= 1'b0;
            rsp_id_q     <= '0;
            // Start just below requester 0 so it wins the first arbitration.
            last_grant_q <= REQ_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            rsp_pend_q   <= rsp_pend_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_riscv_cache_arb.sv
// -----------------------------------------------------------------------------
// tb_riscv_cache_arb
//
// Bench for riscv_cache_arb with a behavioural synchronous-read cache attached.
// Directed table vectors, hand-written reset/clear sequences and a randomized
// phase checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_riscv_cache_arb;

    localparam int NR    = 2;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_enable = 1'b0;
    logic          o_cache_enable;
    logic          o_cache_read;
    logic          o_cache_write;
    logic [AW-1:0] o_cache_rd_addr;
    logic [AW-1:0] o_cache_wr_addr;
    logic [DW-1:0] o_cache_data;
    logic [DW-1:0] i_cache_data;
    logic          o_init_done;

    riscv_cache_arb_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    riscv_cache_arb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_REQ    (NR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_enable        (i_enable),
        .bus             (bus),
        .o_cache_enable  (o_cache_enable),
        .o_cache_read    (o_cache_read),
        .o_cache_write   (o_cache_write),
        .o_cache_rd_addr (o_cache_rd_addr),
        .o_cache_wr_addr (o_cache_wr_addr),
        .o_cache_data    (o_cache_data),
        .i_cache_data    (i_cache_data),
        .o_init_done     (o_init_done)
    );

    always #5 clk = ~clk;

    // Behavioural cache: registered read port that holds when no read is issued,
    // active-low reset driven from ~reset.
    logic [DW-1:0] cache_mem [DEPTH];
    logic          cache_rst_n;
    assign cache_rst_n = ~reset;

    always @(posedge clk) begin
        if (o_cache_enable && o_cache_write) cache_mem[o_cache_wr_addr[7:0]] <= o_cache_data;
        if (!cache_rst_n) i_cache_data <= '0;
        else if (o_cache_enable && o_cache_read) i_cache_data <= cache_mem[o_cache_rd_addr[7:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 2 units later, well away from either clock edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] v, input logic [1:0] w,
                         input logic [1:0] rdy, input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1);
        i_enable           = en;
        bus.i_req_valid    = v;
        bus.i_req_write    = w;
        bus.i_rsp_ready    = rdy;
        bus.i_req_addr[0]  = a0;
        bus.i_req_addr[1]  = a1;
        bus.i_req_wdata[0] = d0;
        bus.i_req_wdata[1] = d1;
    endtask

    // Release reset and follow the clear walk. i_enable is dropped for
    // drop_len cycles starting at walk cycle drop_at.
    task automatic run_init(input int drop_at, input int drop_len);
        int   idx;
        logic en;
        idx   = 0;
        reset = 1'b0;
        for (int c = 0; c < DEPTH + drop_len; c++) begin
            en       = !(c >= drop_at && c < drop_at + drop_len);
            i_enable = en;
            #2;
            check($sformatf("init_write_c%0d", c), 64'(o_cache_write), 64'(en));
            check("init_done_low", 64'(o_init_done), 64'd0);
            if (en) begin
                check($sformatf("init_wr_addr_c%0d", c), o_cache_wr_addr, 64'(idx));
                check("init_wr_data", o_cache_data, 64'd0);
                idx++;
            end
            tick();
        end
        i_enable = 1'b1;
        #2;
        check("init_done_high", 64'(o_init_done), 64'd1);
        check("init_no_write_after", 64'(o_cache_write), 64'd0);
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [1:0]  rdy;
        logic [63:0] a0, a1, d0, d1;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rsp_valid;
        logic [63:0] exp_rsp_data;
        logic        exp_read;
        logic        exp_write;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    typedef struct {
        int          id;
        logic [63:0] data;
    } rsp_t;

    // Reference model state: memory image, outstanding responses, priority pointer.
    rsp_t        exp_q [$];
    rsp_t        new_rsp;
    logic [63:0] ref_mem [DEPTH];
    int          ptr;
    logic        r_en;
    logic [1:0]  r_valid, r_write, r_rdy;
    logic [63:0] r_addr [NR];
    logic [63:0] r_wdata [NR];
    logic [1:0]  exp_rv, exp_rdy;
    logic        accept, rd_ok;
    int          g, c, idx;

    initial begin
        // en valid write rdy  a0  a1  d0  d1  | ready rsp_v rsp_data read write addr wdata
        vecs[0]  = '{1'b1, 2'b11, 2'b00, 2'b11, 64'h7, 64'h3,   64'h0, 64'h0,        2'b01, 2'b00, 64'h0,        1'b1, 1'b0, 64'h7, 64'h0};
        vecs[1]  = '{1'b1, 2'b11, 2'b00, 2'b11, 64'h7, 64'h3,   64'h0, 64'h0,        2'b10, 2'b01, 64'h0,        1'b1, 1'b0, 64'h3, 64'h0};
        vecs[2]  = '{1'b1, 2'b11, 2'b00, 2'b11, 64'h7, 64'h3,   64'h0, 64'h0,        2'b01, 2'b10, 64'h0,        1'b1, 1'b0, 64'h7, 64'h0};
        vecs[3]  = '{1'b1, 2'b10, 2'b10, 2'b11, 64'h0, 64'h105, 64'h0, 64'hDEADBEEF, 2'b10, 2'b01, 64'h0,        1'b0, 1'b1, 64'h5, 64'hDEADBEEF};
        vecs[4]  = '{1'b1, 2'b01, 2'b00, 2'b11, 64'h5, 64'h0,   64'h0, 64'h0,        2'b01, 2'b00, 64'h0,        1'b1, 1'b0, 64'h5, 64'h0};
        vecs[5]  = '{1'b1, 2'b00, 2'b00, 2'b01, 64'h0, 64'h0,   64'h0, 64'h0,        2'b00, 2'b01, 64'hDEADBEEF, 1'b0, 1'b0, 64'h0, 64'h0};
        vecs[6]  = '{1'b1, 2'b00, 2'b00, 2'b11, 64'h0, 64'h0,   64'h0, 64'h0,        2'b00, 2'b00, 64'h0,        1'b0, 1'b0, 64'h0, 64'h0};
        vecs[7]  = '{1'b1, 2'b01, 2'b00, 2'b00, 64'h5, 64'h0,   64'h0, 64'h0,        2'b01, 2'b00, 64'h0,        1'b1, 1'b0, 64'h5, 64'h0};
        vecs[8]  = '{1'b1, 2'b10, 2'b00, 2'b00, 64'h0, 64'h3,   64'h0, 64'h0,        2'b00, 2'b01, 64'hDEADBEEF, 1'b0, 1'b0, 64'h0, 64'h0};
        vecs[9]  = '{1'b1, 2'b10, 2'b10, 2'b00, 64'h0, 64'h5,   64'h0, 64'h1234,     2'b10, 2'b01, 64'hDEADBEEF, 1'b0, 1'b1, 64'h5, 64'h1234};
        vecs[10] = '{1'b1, 2'b10, 2'b00, 2'b00, 64'h0, 64'h3,   64'h0, 64'h0,        2'b00, 2'b01, 64'hDEADBEEF, 1'b0, 1'b0, 64'h0, 64'h0};
        vecs[11] = '{1'b1, 2'b10, 2'b00, 2'b01, 64'h0, 64'h5,   64'h0, 64'h0,        2'b10, 2'b01, 64'hDEADBEEF, 1'b1, 1'b0, 64'h5, 64'h0};
        vecs[12] = '{1'b1, 2'b00, 2'b00, 2'b10, 64'h0, 64'h0,   64'h0, 64'h0,        2'b00, 2'b10, 64'h1234,     1'b0, 1'b0, 64'h0, 64'h0};
        vecs[13] = '{1'b0, 2'b01, 2'b00, 2'b11, 64'h5, 64'h0,   64'h0, 64'h0,        2'b00, 2'b00, 64'h0,        1'b0, 1'b0, 64'h0, 64'h0};
        vecs[14] = '{1'b1, 2'b01, 2'b00, 2'b00, 64'h5, 64'h0,   64'h0, 64'h0,        2'b01, 2'b00, 64'h0,        1'b1, 1'b0, 64'h5, 64'h0};
        vecs[15] = '{1'b0, 2'b10, 2'b00, 2'b01, 64'h0, 64'h5,   64'h0, 64'h0,        2'b00, 2'b01, 64'h1234,     1'b0, 1'b0, 64'h0, 64'h0};
        vecs[16] = '{1'b1, 2'b00, 2'b00, 2'b11, 64'h0, 64'h0,   64'h0, 64'h0,        2'b00, 2'b00, 64'h0,        1'b0, 1'b0, 64'h0, 64'h0};

        // ---------------- reset values ----------------
        drive(1'b1, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        tick();
        tick();
        #2;
        check("rst_req_ready", 64'(bus.o_req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("rst_init_done", 64'(o_init_done), 64'd0);
        check("rst_cache_read", 64'(o_cache_read), 64'd0);
        check("cache_enable", 64'(o_cache_enable), 64'd1);
        tick();

        // ---------------- clear walk, enable held ----------------
        run_init(0, 0);

        // ---------------- directed table ----------------
        tick();
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].en, vecs[i].valid, vecs[i].write, vecs[i].rdy,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            #2;
            check($sformatf("vec%0d_req_ready", i), 64'(bus.o_req_ready), 64'(vecs[i].exp_ready));
            check($sformatf("vec%0d_rsp_valid", i), 64'(bus.o_rsp_valid), 64'(vecs[i].exp_rsp_valid));
            if (vecs[i].exp_rsp_valid != 2'b00)
                check($sformatf("vec%0d_rsp_data", i), bus.o_rsp_data, vecs[i].exp_rsp_data);
            check($sformatf("vec%0d_cache_read", i), 64'(o_cache_read), 64'(vecs[i].exp_read));
            check($sformatf("vec%0d_cache_write", i), 64'(o_cache_write), 64'(vecs[i].exp_write));
            if (vecs[i].exp_read)
                check($sformatf("vec%0d_rd_addr", i), o_cache_rd_addr, vecs[i].exp_addr);
            if (vecs[i].exp_write) begin
                check($sformatf("vec%0d_wr_addr", i), o_cache_wr_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_wr_data", i), o_cache_data, vecs[i].exp_wdata);
            end
            tick();
        end

        // ---------------- reset while a response is pending ----------------
        drive(1'b1, 2'b01, 2'b00, 2'b00, 64'h9, 64'h0, 64'h0, 64'h0);
        #2;
        check("rstpend_grant", 64'(bus.o_req_ready), 64'd1);
        tick();
        drive(1'b1, 2'b00, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        #2;
        check("rstpend_valid_before", 64'(bus.o_rsp_valid), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        #2;
        check("rstpend_valid_dropped", 64'(bus.o_rsp_valid), 64'd0);
        check("rstpend_init_done", 64'(o_init_done), 64'd0);
        tick();

        // ---------------- clear walk with enable dropped at index 100 ----------------
        run_init(100, 5);

        // ---------------- randomized traffic vs reference model ----------------
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_q.delete();
        ptr = NR - 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            r_en = ($urandom_range(9) != 0);
            for (int i = 0; i < NR; i++) begin
                r_valid[i]   = ($urandom_range(3) != 0);
                r_write[i]   = ($urandom_range(1) != 0);
                r_rdy[i]     = ($urandom_range(3) != 0);
                r_addr[i]    = {$urandom(), $urandom()};
                r_addr[i][7:0] = 8'($urandom_range(15));
                r_wdata[i]   = {$urandom(), $urandom()};
            end
            drive(r_en, r_valid, r_write, r_rdy, r_addr[0], r_addr[1], r_wdata[0], r_wdata[1]);
            #2;

            exp_rv = '0;
            if (exp_q.size() > 0) exp_rv[exp_q[0].id] = 1'b1;
            check("rnd_rsp_valid", 64'(bus.o_rsp_valid), 64'(exp_rv));
            if (exp_q.size() > 0) check("rnd_rsp_data", bus.o_rsp_data, exp_q[0].data);

            accept = (exp_q.size() > 0) && r_rdy[exp_q[0].id];
            rd_ok  = (exp_q.size() == 0) || accept;
            g = -1;
            for (int k = 1; k <= NR; k++) begin
                c = (ptr + k) % NR;
                if (g < 0 && r_en && r_valid[c] && (r_write[c] || rd_ok)) g = c;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("rnd_req_ready", 64'(bus.o_req_ready), 64'(exp_rdy));
            check("rnd_cache_read", 64'(o_cache_read), 64'(g >= 0 && !r_write[g]));
            check("rnd_cache_write", 64'(o_cache_write), 64'(g >= 0 && r_write[g]));

            if (accept) void'(exp_q.pop_front());
            if (g >= 0) begin
                idx = int'(r_addr[g][7:0]);
                ptr = g;
                if (r_write[g]) begin
                    check("rnd_wr_addr", o_cache_wr_addr, 64'(idx));
                    check("rnd_wr_data", o_cache_data, r_wdata[g]);
                    ref_mem[idx] = r_wdata[g];
                end else begin
                    check("rnd_rd_addr", o_cache_rd_addr, 64'(idx));
                    new_rsp.id   = g;
                    new_rsp.data = ref_mem[idx];
                    exp_q.push_back(new_rsp);
                end
            end
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion before time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
